// File: rtl/uart_fifo_core.sv
// UART transmitter and 16x-oversampled receiver with small TX/RX FIFOs.
// Byte streams use valid/ready; RX entries carry their own error flags.
`timescale 1ns/1ps
module uart_fifo_core #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rxd,
   output logic                 txd,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 rx_overrun_clr,
   output logic                 tx_busy
);

   localparam int DIV   = CLK_HZ / (BAUD * 16);
   localparam int BW    = $clog2(DIV);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int RW    = DATA_BITS + 2;
   localparam logic [BW-1:0]    DIV_M1   = BW'(DIV - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [4:0]       STOP_END = 5'(16 * STOP_BITS - 1);
   localparam logic             POL      = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP
   } state_t;

   logic [BW-1:0] bcnt;
   logic          tick;

   assign tick = (bcnt == DIV_M1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bcnt <= '0;
      else          bcnt <= tick ? '0 : bcnt + 1'b1;
   end

   logic rx_m, rx_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rxd;
         rx_s <= rx_m;
      end
   end

   // TX FIFO
   logic [DATA_BITS-1:0] tx_mem [DEPTH];
   logic [FIFO_AW-1:0]   tx_wp, tx_rp;
   logic [FIFO_AW:0]     tx_lvl, tx_lvl_n;
   logic                 tx_push, tx_pop, tx_empty;

   state_t               ts;
   logic [4:0]           tcnt;
   logic [2:0]           tbit;
   logic [DATA_BITS-1:0] tsh;
   logic                 tpar;

   assign tx_push  = tx_valid & tx_ready;
   assign tx_empty = (tx_lvl == '0);
   assign tx_pop   = tick & ~tx_empty &
                     ((ts == S_IDLE) | ((ts == S_STOP) & (tcnt == STOP_END)));
   assign tx_busy  = (ts != S_IDLE) | ~tx_empty;

   always_comb begin
      tx_lvl_n = tx_lvl;
      unique case ({tx_push, tx_pop})
         2'b10:   tx_lvl_n = tx_lvl + 1'b1;
         2'b01:   tx_lvl_n = tx_lvl - 1'b1;
         default: tx_lvl_n = tx_lvl;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_lvl   <= '0;
         tx_ready <= 1'b1;
      end else begin
         tx_lvl   <= tx_lvl_n;
         tx_ready <= (tx_lvl_n != FULL_LVL);
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   // TX FSM; a pop at the end of STOP starts the next frame with no gap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts   <= S_IDLE;
         txd  <= 1'b1;
         tcnt <= '0;
         tbit <= '0;
         tsh  <= '0;
         tpar <= 1'b0;
      end else if (tick) begin
         tcnt <= tcnt + 5'd1;
         if (tx_pop) begin
            tsh  <= tx_mem[tx_rp];
            tpar <= ^tx_mem[tx_rp] ^ POL;
            txd  <= 1'b0;
            ts   <= S_START;
            tcnt <= '0;
         end else begin
            unique case (ts)
               S_IDLE: tcnt <= '0;
               S_START: if (tcnt == 5'd15) begin
                  tcnt <= '0;
                  tbit <= '0;
                  txd  <= tsh[0];
                  ts   <= S_DATA;
               end
               S_DATA: if (tcnt == 5'd15) begin
                  tcnt <= '0;
                  if (tbit == LAST_BIT) begin
                     if (PARITY != 0) begin
                        txd <= tpar;
                        ts  <= S_PAR;
                     end else begin
                        txd <= 1'b1;
                        ts  <= S_STOP;
                     end
                  end else begin
                     tbit <= tbit + 3'd1;
                     txd  <= tsh[1];
                     tsh  <= tsh >> 1;
                  end
               end
               S_PAR: if (tcnt == 5'd15) begin
                  tcnt <= '0;
                  txd  <= 1'b1;
                  ts   <= S_STOP;
               end
               S_STOP: if (tcnt == STOP_END) begin
                  tcnt <= '0;
                  ts   <= S_IDLE;
               end
               default: ts <= S_IDLE;
            endcase
         end
      end
   end

   // RX FSM; samples land 8 ticks after start detection, then every 16
   state_t               rs;
   logic [3:0]           rcnt;
   logic [2:0]           rbit;
   logic [DATA_BITS-1:0] rsh;
   logic                 rpe;
   logic                 rx_push;
   logic [RW-1:0]        rx_wdata;

   assign rx_push  = tick & (rs == S_STOP) & (rcnt == 4'd15);
   assign rx_wdata = {~rx_s, rpe, rsh};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rs   <= S_IDLE;
         rcnt <= '0;
         rbit <= '0;
         rsh  <= '0;
         rpe  <= 1'b0;
      end else if (tick) begin
         rcnt <= rcnt + 4'd1;
         unique case (rs)
            S_IDLE: begin
               rcnt <= '0;
               if (!rx_s) begin
                  rpe <= 1'b0;
                  rs  <= S_START;
               end
            end
            S_START: if (rcnt == 4'd7) begin
               rcnt <= '0;
               rbit <= '0;
               rs   <= rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rcnt == 4'd15) begin
               rcnt <= '0;
               rsh  <= {rx_s, rsh[DATA_BITS-1:1]};
               if (rbit == LAST_BIT) rs <= (PARITY != 0) ? S_PAR : S_STOP;
               else                  rbit <= rbit + 3'd1;
            end
            S_PAR: if (rcnt == 4'd15) begin
               rcnt <= '0;
               rpe  <= (rx_s != (^rsh ^ POL));
               rs   <= S_STOP;
            end
            S_STOP: if (rcnt == 4'd15) begin
               rcnt <= '0;
               rs   <= S_IDLE;
            end
            default: rs <= S_IDLE;
         endcase
      end
   end

   // RX FIFO
   logic [RW-1:0]      rx_mem [DEPTH];
   logic [FIFO_AW-1:0] rx_wp, rx_rp;
   logic [FIFO_AW:0]   rx_lvl;
   logic               rx_pop, rx_acc, rx_drop;
   logic [RW-1:0]      rx_head;

   assign rx_valid = (rx_lvl != '0);
   assign rx_pop   = rx_valid & rx_ready;
   assign rx_acc   = rx_push & ((rx_lvl != FULL_LVL) | rx_pop);
   assign rx_drop  = rx_push & ~rx_acc;
   assign rx_head  = rx_mem[rx_rp];

   assign rx_data       = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
   assign rx_frame_err  = rx_valid & rx_head[RW-1];
   assign rx_parity_err = (PARITY != 0) & rx_valid & rx_head[RW-2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_wp      <= '0;
         rx_rp      <= '0;
         rx_lvl     <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_acc) rx_wp <= rx_wp + 1'b1;
         if (rx_pop) rx_rp <= rx_rp + 1'b1;
         unique case ({rx_acc, rx_pop})
            2'b10:   rx_lvl <= rx_lvl + 1'b1;
            2'b01:   rx_lvl <= rx_lvl - 1'b1;
            default: rx_lvl <= rx_lvl;
         endcase
         if (rx_drop)             rx_overrun <= 1'b1;
         else if (rx_overrun_clr) rx_overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_acc) rx_mem[rx_wp] <= rx_wdata;
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: 8N1 instance (a) and 8E1 instance (b).
// Expected RX entries are queued at stimulus time and checked by monitors.
`timescale 1ns/1ps
module tb_uart_fifo_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] tx_data;
   logic       brxd, tgt, lb_a, lb_b;

   logic       txd_a, rxd_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
   logic       pe_a, fe_a, ovr_a, ovr_clr_a, busy_a;
   logic [7:0] rx_data_a;
   logic       txd_b, rxd_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
   logic       pe_b, fe_b, ovr_b, ovr_clr_b, busy_b;
   logic [7:0] rx_data_b;

   assign rxd_a = lb_a ? txd_a : (tgt ? 1'b1 : brxd);
   assign rxd_b = lb_b ? txd_b : (tgt ? brxd : 1'b1);

   uart_fifo_core #(.PARITY(0)) dut_a (
      .clk(clk), .reset_n(rst_n), .rxd(rxd_a), .txd(txd_a),
      .tx_data(tx_data), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
      .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ovr_a),
      .rx_overrun_clr(ovr_clr_a), .tx_busy(busy_a)
   );

   uart_fifo_core #(.PARITY(2)) dut_b (
      .clk(clk), .reset_n(rst_n), .rxd(rxd_b), .txd(txd_b),
      .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
      .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ovr_b),
      .rx_overrun_clr(ovr_clr_b), .tx_busy(busy_b)
   );

   typedef logic [9:0] ent_t;
   ent_t qa[$];
   ent_t qb[$];

   int          nvec = 0;
   int          nerr = 0;
   int unsigned cyc  = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitors: compare each popped head {fe, pe, data}
   always @(negedge clk) begin
      if (rst_n && rx_valid_a && rx_ready_a) begin
         if (qa.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL rx_a unexpected: got %0h", {fe_a, pe_a, rx_data_a});
         end else begin
            chk("rx_a entry", {fe_a, pe_a, rx_data_a}, qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rx_valid_b && rx_ready_b) begin
         if (qb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL rx_b unexpected: got %0h", {fe_b, pe_b, rx_data_b});
         end else begin
            chk("rx_b entry", {fe_b, pe_b, rx_data_b}, qb.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic line(input bit b);
      return b ? txd_b : txd_a;
   endfunction

   task automatic push(input bit b, input logic [7:0] d, input bit exp_rx);
      int n = 0;
      tx_data = d;
      if (b) tx_valid_b = 1'b1;
      else   tx_valid_a = 1'b1;
      while (!(b ? tx_ready_b : tx_ready_a) && n < 30000) begin
         step(1);
         n++;
      end
      if (n >= 30000) chk("push timeout", 32'd1, 32'd0);
      step(1);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      if (exp_rx) begin
         if (b) qb.push_back({2'b00, d});
         else   qa.push_back({2'b00, d});
      end
   endtask

   task automatic wait_fall(input bit b, output int unsigned t0);
      int n = 0;
      while (line(b) !== 1'b0 && n < 10000) begin
         step(1);
         n++;
      end
      if (n >= 10000) chk("start edge timeout", 32'd1, 32'd0);
      t0 = cyc;
   endtask

   task automatic check_line(input bit b, input logic [15:0] bits,
                             input int nb, input string nm,
                             output int unsigned t0);
      wait_fall(b, t0);
      step(216);
      chk(nm, line(b), bits[0]);
      for (int k = 1; k < nb; k++) begin
         step(432);
         chk(nm, line(b), bits[k]);
      end
   endtask

   task automatic send(input logic [7:0] d, input bit pen, input bit pbit,
                       input bit stop);
      brxd = 1'b0;
      step(432);
      for (int i = 0; i < 8; i++) begin
         brxd = d[i];
         step(432);
      end
      if (pen) begin
         brxd = pbit;
         step(432);
      end
      brxd = stop;
      step(432);
      brxd = 1'b1;
   endtask

   task automatic wait_q(input bit b);
      int n = 0;
      while ((b ? qb.size() : qa.size()) != 0 && n < 12000) begin
         step(1);
         n++;
      end
      chk(b ? "queue b drained" : "queue a drained",
          b ? qb.size() : qa.size(), 0);
   endtask

   initial begin
      int unsigned t0;
      int unsigned lat;
      int          n;

      rst_n      = 1'b0;
      tx_data    = '0;
      brxd       = 1'b1;
      tgt        = 1'b0;
      lb_a       = 1'b1;
      lb_b       = 1'b1;
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      rx_ready_a = 1'b1;
      rx_ready_b = 1'b1;
      ovr_clr_a  = 1'b0;
      ovr_clr_b  = 1'b0;
      step(5);
      chk("rst txd", txd_a, 1'b1);
      chk("rst tx_ready", tx_ready_a, 1'b1);
      chk("rst rx_valid", rx_valid_a, 1'b0);
      chk("rst rx_data", rx_data_a, 8'h00);
      chk("rst flags", {pe_a, fe_a, ovr_a}, 3'b000);
      chk("rst tx_busy", busy_a, 1'b0);
      chk("rst b", {txd_b, tx_ready_b, rx_valid_b, busy_b}, 4'b1100);
      rst_n = 1'b1;
      step(2);

      // 8N1 loopback of 0xA5
      push(1'b0, 8'hA5, 1'b1);
      check_line(1'b0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, "t1 txd bit", t0);
      n = 0;
      while (!rx_valid_a && n < 200) begin
         step(1);
         n++;
      end
      lat = cyc - t0;
      chk("t1 rx latency ok", (lat >= 4100 && lat <= 4140), 1'b1);
      wait_q(1'b0);

      // 8E1: line parity for 0x07 is 1, then a flipped parity bit
      push(1'b1, 8'h07, 1'b1);
      check_line(1'b1, {5'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "t2 txd bit", t0);
      wait_q(1'b1);
      lb_b = 1'b0;
      tgt  = 1'b1;
      step(10);
      qb.push_back({2'b01, 8'h07});
      send(8'h07, 1'b1, 1'b0, 1'b1);
      step(432);
      wait_q(1'b1);
      tgt = 1'b0;

      // Framing error then a clean frame
      lb_a = 1'b0;
      step(10);
      qa.push_back({2'b10, 8'h3C});
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      step(864);
      qa.push_back({2'b00, 8'h5A});
      send(8'h5A, 1'b0, 1'b0, 1'b1);
      step(432);
      wait_q(1'b0);

      // RX FIFO overrun: 5 frames into a 4-deep FIFO
      lb_a       = 1'b1;
      rx_ready_a = 1'b0;
      for (int i = 1; i <= 5; i++) push(1'b0, 8'(i), i <= 4);
      n = 0;
      while (busy_a && n < 30000) begin
         step(1);
         n++;
      end
      chk("t4 tx drained", busy_a, 1'b0);
      step(50);
      chk("t4 overrun", ovr_a, 1'b1);
      chk("t4 head", {rx_valid_a, rx_data_a}, 9'h101);
      ovr_clr_a = 1'b1;
      step(1);
      ovr_clr_a = 1'b0;
      chk("t4 overrun clr", ovr_a, 1'b0);
      rx_ready_a = 1'b1;
      wait_q(1'b0);
      step(2);
      chk("t4 rx empty", rx_valid_a, 1'b0);

      // Start-bit glitch of 5 ticks is rejected
      lb_a = 1'b0;
      brxd = 1'b0;
      step(135);
      brxd = 1'b1;
      step(864);
      chk("t5 glitch no push", rx_valid_a, 1'b0);

      // TX FIFO fills while a frame is on the line
      push(1'b0, 8'h11, 1'b0);
      wait_fall(1'b0, t0);
      push(1'b0, 8'h22, 1'b0);
      push(1'b0, 8'h33, 1'b0);
      push(1'b0, 8'h44, 1'b0);
      push(1'b0, 8'h55, 1'b0);
      chk("t5 tx full", tx_ready_a, 1'b0);
      step(2000);
      chk("t5 still full", tx_ready_a, 1'b0);
      n = 0;
      while (!tx_ready_a && n < 5000) begin
         step(1);
         n++;
      end
      chk("t5 ready at pop", cyc - t0, 32'd4320);
      chk("t5 back-to-back start", txd_a, 1'b0);

      // Reset in DATA bit 3, then a normal frame
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(2);
      chk("t6 idle after reset", busy_a, 1'b0);
      lb_a = 1'b1;
      push(1'b0, 8'hFF, 1'b0);
      wait_fall(1'b0, t0);
      step(216 + 432 * 4);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6 txd async", txd_a, 1'b1);
      chk("t6 busy", busy_a, 1'b0);
      chk("t6 rx_valid", rx_valid_a, 1'b0);
      step(3);
      rst_n = 1'b1;
      step(2);
      push(1'b0, 8'h96, 1'b1);
      check_line(1'b0, {6'h0, 1'b1, 8'h96, 1'b0}, 10, "t6 txd bit", t0);
      step(100);
      wait_q(1'b0);
      chk("qb empty", qb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
